alu_issue_stage: RTL and testbench

Operand-fetch, issue and writeback controller that sits directly upstream of the ALU. It accepts one instruction word per handshake, reads two operands from an 8 x 32 register file (or substitutes a sign-extended immediate), and drives OPCode/DataA/DataB into the ALU. After a fixed latency it writes the ALU result back to the destination register and latches the 4-bit status. Only one instruction is in flight at a time, so there are no operand hazards.

---
 rtl/alu_issue_stage.sv | 159 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand-fetch, issue and writeback controller placed in front of the ALU.
//   Accepts one instruction per handshake, reads operands from an 8 x 32
//   register file (or a sign-extended immediate), drives the ALU, waits a
//   fixed latency, then writes the result back and latches the ALU status.
//   Only one instruction is ever in flight.
//
// Ports
//   Clock        in   1   rising-edge clock
//   Reset_n      in   1   asynchronous active-low reset
//   InstrIn      in  32   {opcode[31:26], rd[25:23], rs[22:20], rt[19:17],
//                          imm_sel[16], imm[15:0]}
//   InstrValid   in   1   InstrIn is valid
//   InstrReady   out  1   block can accept an instruction (registered)
//   OPCode       out  6   opcode to ALU (NOP_OP when idle)
//   DataA        out 32   operand A to ALU
//   DataB        out 32   operand B to ALU
//   ResultC      in  32   ALU result
//   Status       in   4   ALU status {Over, Carry, Zero, Neg}
//   StatusReg    out  4   status of the last retired instruction
//   Done         out  1   one-cycle pulse after an instruction retires
//   DbgAddr      in   3   debug read address
//   DbgData      out 32   combinational read of regfile[DbgAddr]
//
// State | meaning
// IDLE  | ready for an instruction; captures InstrIn on handshake
// ISSUE | operands and opcode registered onto the ALU inputs
// WAIT  | ALU latency countdown, ALU inputs held stable
// WB    | result written to rd, status latched, opcode returns to NOP

module alu_issue_stage #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [5:0]  NOP_OP      = 6'b111111
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] InstrIn,
  input  logic        InstrValid,
  output logic        InstrReady,
  output logic [5:0]  OPCode,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  input  logic [31:0] ResultC,
  input  logic [3:0]  Status,
  output logic [3:0]  StatusReg,
  output logic        Done,
  input  logic [2:0]  DbgAddr,
  output logic [31:0] DbgData
);

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_ready;
  logic        r_done;
  logic [31:0] r_instr;
  logic [2:0]  r_cnt;
  logic [5:0]  r_opcode;
  logic [31:0] r_data_a;
  logic [31:0] r_data_b;
  logic [3:0]  r_status;
  logic [31:0] r_rf [8];

  logic        w_accept;
  logic [5:0]  w_opcode;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic        w_imm_sel;
  logic [15:0] w_imm;
  logic [31:0] w_imm_sext;

  assign w_opcode   = r_instr[31:26];
  assign w_rd       = r_instr[25:23];
  assign w_rs       = r_instr[22:20];
  assign w_rt       = r_instr[19:17];
  assign w_imm_sel  = r_instr[16];
  assign w_imm      = r_instr[15:0];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};

  // InstrReady is only ever high in IDLE, so it alone qualifies the handshake
  // (it is still low during the first IDLE cycle after reset).
  assign w_accept = (r_state == S_IDLE) && InstrValid && r_ready;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_instr  <= '0;
      r_cnt    <= '0;
      r_opcode <= NOP_OP;
      r_data_a <= '0;
      r_data_b <= '0;
      r_status <= '0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      // Ready tracks the state being entered, so it is already high in the
      // Done cycle and the next handshake can land L+3 edges after the last.
      r_ready <= (w_next == S_IDLE);
      r_done  <= (r_state == S_WB);
      if (w_accept) r_instr <= InstrIn;
      case (r_state)
        S_ISSUE: begin
          r_data_a <= r_rf[w_rs];
          r_data_b <= w_imm_sel ? w_imm_sext : r_rf[w_rt];
          r_opcode <= w_opcode;
          r_cnt    <= LAT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
        end
        S_WB: begin
          // Entry 0 is never written, so it stays zero and reads of R0 need no mux.
          if (w_rd != 3'd0) r_rf[w_rd] <= ResultC;
          r_status <= Status;
          r_opcode <= NOP_OP;
        end
        default: ;
      endcase
    end
  end

  assign InstrReady = r_ready;
  assign Done       = r_done;
  assign OPCode     = r_opcode;
  assign DataA      = r_data_a;
  assign DataB      = r_data_b;
  assign StatusReg  = r_status;
  assign DbgData    = (DbgAddr == 3'd0) ? 32'd0 : r_rf[DbgAddr];

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int LA = 1;
  localparam int LB = 3;
  localparam logic [5:0] NOP = 6'b111111;

  logic clk;
  logic rst_n;

  // DUT A: ALU_LATENCY = 1
  logic [31:0] a_instr;
  logic        a_valid;
  logic        a_ready;
  logic [5:0]  a_op;
  logic [31:0] a_da;
  logic [31:0] a_db;
  logic [31:0] a_res;
  logic [3:0]  a_stat;
  logic [3:0]  a_sreg;
  logic        a_done;
  logic [2:0]  a_dbg;
  logic [31:0] a_dbg_data;

  // DUT B: ALU_LATENCY = 3
  logic [31:0] b_instr;
  logic        b_valid;
  logic        b_ready;
  logic [5:0]  b_op;
  logic [31:0] b_da;
  logic [31:0] b_db;
  logic [31:0] b_res;
  logic [3:0]  b_stat;
  logic [3:0]  b_sreg;
  logic        b_done;
  logic [2:0]  b_dbg;
  logic [31:0] b_dbg_data;

  // ALU stubs: C = A + B, Status = {0, 0, Zero, Neg}
  assign a_res  = a_da + a_db;
  assign a_stat = {2'b00, (a_res == 32'd0), a_res[31]};
  assign b_res  = b_da + b_db;
  assign b_stat = {2'b00, (b_res == 32'd0), b_res[31]};

  alu_issue_stage #(.ALU_LATENCY(LA)) u_dut_a (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .InstrIn    (a_instr),
    .InstrValid (a_valid),
    .InstrReady (a_ready),
    .OPCode     (a_op),
    .DataA      (a_da),
    .DataB      (a_db),
    .ResultC    (a_res),
    .Status     (a_stat),
    .StatusReg  (a_sreg),
    .Done       (a_done),
    .DbgAddr    (a_dbg),
    .DbgData    (a_dbg_data)
  );

  alu_issue_stage #(.ALU_LATENCY(LB)) u_dut_b (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .InstrIn    (b_instr),
    .InstrValid (b_valid),
    .InstrReady (b_ready),
    .OPCode     (b_op),
    .DataA      (b_da),
    .DataB      (b_db),
    .ResultC    (b_res),
    .Status     (b_stat),
    .StatusReg  (b_sreg),
    .Done       (b_done),
    .DbgAddr    (b_dbg),
    .DbgData    (b_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt,
                                     input logic sel, input logic [15:0] imm);
    return {op, rd, rs, rt, sel, imm};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  exp_op;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] rf_m [8];

  // One instruction on DUT A with full timing and writeback checks.
  task automatic run_a(input int i);
    int k;
    int done_at;
    logic [2:0]  rd;
    logic [31:0] old_v;
    logic [31:0] new_v;
    rd    = tbl[i].instr[25:23];
    old_v = rf_m[rd];
    new_v = (rd == 3'd0) ? 32'd0 : tbl[i].exp_res;
    k = 0;
    while (!a_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d_ready", i), {31'd0, a_ready}, 32'd1);
    a_instr = tbl[i].instr;
    a_valid = 1'b1;
    a_dbg   = rd;
    @(negedge clk);
    a_valid = 1'b0;
    a_instr = 32'hA5A5_5A5A;
    @(negedge clk);
    chk($sformatf("v%0d_opcode", i), {26'd0, a_op}, {26'd0, tbl[i].exp_op});
    chk($sformatf("v%0d_dataA", i), a_da, tbl[i].exp_a);
    chk($sformatf("v%0d_dataB", i), a_db, tbl[i].exp_b);
    done_at = 0;
    for (int c = 2; c <= 12 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1 + LA) chk($sformatf("v%0d_wb_old", i), a_dbg_data, old_v);
      if (a_done) done_at = c;
    end
    chk($sformatf("v%0d_done_cycle", i), done_at, 2 + LA);
    chk($sformatf("v%0d_rd_new", i), a_dbg_data, new_v);
    chk($sformatf("v%0d_status", i), {28'd0, a_sreg}, {28'd0, tbl[i].exp_st});
    chk($sformatf("v%0d_op_nop", i), {26'd0, a_op}, {26'd0, NOP});
    chk($sformatf("v%0d_ready_done", i), {31'd0, a_ready}, 32'd1);
    rf_m[rd] = new_v;
  endtask

  logic [31:0] bl [3];
  int          dtime [3];

  initial begin
    int acc;
    int nd;
    int seen;

    tbl[0] = '{mk(6'b010000, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5),      6'b010000, 32'd0,         32'd5,         32'd5,         4'b0000};
    tbl[1] = '{mk(6'b010000, 3'd2, 3'd0, 3'd0, 1'b1, 16'd10),     6'b010000, 32'd0,         32'd10,        32'd10,        4'b0000};
    tbl[2] = '{mk(6'b010000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000),   6'b010000, 32'd5,         32'd10,        32'd15,        4'b0000};
    tbl[3] = '{mk(6'b010000, 3'd4, 3'd0, 3'd0, 1'b1, 16'hFFFB),   6'b010000, 32'd0,         32'hFFFFFFFB,  32'hFFFFFFFB,  4'b0001};
    tbl[4] = '{mk(6'b010000, 3'd0, 3'd4, 3'd0, 1'b1, 16'd5),      6'b010000, 32'hFFFFFFFB,  32'd5,         32'd0,         4'b0010};
    tbl[5] = '{mk(6'b010000, 3'd3, 3'd3, 3'd3, 1'b0, 16'h1234),   6'b010000, 32'd15,        32'd15,        32'd30,        4'b0000};
    tbl[6] = '{mk(6'b111111, 3'd5, 3'd1, 3'd0, 1'b1, 16'd1),      6'b111111, 32'd5,         32'd1,         32'd6,         4'b0000};
    tbl[7] = '{mk(6'b000001, 3'd6, 3'd4, 3'd1, 1'b0, 16'hFFFF),   6'b000001, 32'hFFFFFFFB,  32'd5,         32'd0,         4'b0010};
    tbl[8] = '{mk(6'b101010, 3'd7, 3'd0, 3'd0, 1'b1, 16'h7FFF),   6'b101010, 32'd0,         32'h00007FFF,  32'h00007FFF,  4'b0000};
    tbl[9] = '{mk(6'b010000, 3'd2, 3'd7, 3'd0, 1'b1, 16'h8000),   6'b010000, 32'h00007FFF,  32'hFFFF8000,  32'hFFFFFFFF,  4'b0001};
    for (int i = 0; i < 8; i++) rf_m[i] = 32'd0;

    bl[0] = mk(6'b010000, 3'd1, 3'd0, 3'd0, 1'b1, 16'd1);
    bl[1] = mk(6'b010000, 3'd2, 3'd0, 3'd0, 1'b1, 16'd2);
    bl[2] = mk(6'b010000, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0);

    rst_n   = 1'b0;
    a_instr = 32'd0;
    a_valid = 1'b0;
    a_dbg   = 3'd0;
    b_instr = 32'd0;
    b_valid = 1'b0;
    b_dbg   = 3'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_opcode", {26'd0, a_op}, {26'd0, NOP});
    chk("rst_dataA", a_da, 32'd0);
    chk("rst_dataB", a_db, 32'd0);
    chk("rst_status", {28'd0, a_sreg}, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_low", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready_high", {31'd0, a_ready}, 32'd1);
    chk("rel_ready_high_b", {31'd0, b_ready}, 32'd1);

    // Table-driven vectors, latency 1
    for (int i = 0; i < 10; i++) run_a(i);

    // Back-to-back with InstrValid held high, latency 3
    acc = 0;
    nd  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b_done) begin
        if (nd < 3) dtime[nd] = c;
        nd++;
      end
      if (acc < 3) begin
        b_valid = 1'b1;
        if (b_ready) begin
          b_instr = bl[acc];
          acc++;
        end else begin
          b_instr = $urandom();
        end
      end else begin
        b_valid = 1'b0;
      end
    end
    chk("b2b_done_count", nd, 3);
    chk("b2b_first_latency", dtime[0], 6);
    chk("b2b_spacing_1", dtime[1] - dtime[0], 6);
    chk("b2b_spacing_2", dtime[2] - dtime[1], 6);
    b_dbg = 3'd1;
    #1 chk("b2b_r1", b_dbg_data, 32'd1);
    b_dbg = 3'd2;
    #1 chk("b2b_r2", b_dbg_data, 32'd2);
    b_dbg = 3'd3;
    #1 chk("b2b_r3", b_dbg_data, 32'd3);

    // Stability: InstrIn/InstrValid churn while the instruction is in flight
    @(negedge clk);
    chk("stab_ready", {31'd0, b_ready}, 32'd1);
    b_instr = mk(6'b001100, 3'd4, 3'd0, 3'd0, 1'b1, 16'hFFFF);
    b_valid = 1'b1;
    @(negedge clk);
    b_instr = $urandom();
    b_valid = 1'b0;
    for (int j = 1; j <= LB + 1; j++) begin
      @(negedge clk);
      chk($sformatf("stab_op_%0d", j), {26'd0, b_op}, {26'd0, 6'b001100});
      chk($sformatf("stab_A_%0d", j), b_da, 32'd0);
      chk($sformatf("stab_B_%0d", j), b_db, 32'hFFFFFFFF);
      b_instr = $urandom();
      b_valid = (j < LB + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    chk("stab_op_nop", {26'd0, b_op}, {26'd0, NOP});
    chk("stab_done", {31'd0, b_done}, 32'd1);
    chk("stab_status", {28'd0, b_sreg}, 32'd1);

    // Reset mid-WAIT aborts the instruction
    b_instr = mk(6'b010000, 3'd5, 3'd3, 3'd0, 1'b1, 16'd1);
    b_valid = 1'b1;
    b_dbg   = 3'd3;
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    chk("abort_dataA", b_da, 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("abort_done_%0d", j), {31'd0, b_done}, 32'd0);
    end
    chk("abort_opcode", {26'd0, b_op}, {26'd0, NOP});
    chk("abort_dataA0", b_da, 32'd0);
    chk("abort_dataB0", b_db, 32'd0);
    chk("abort_status", {28'd0, b_sreg}, 32'd0);
    chk("abort_r3", b_dbg_data, 32'd0);
    chk("abort_ready", {31'd0, b_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_rel", {31'd0, b_ready}, 32'd1);
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (b_done) seen++;
    end
    chk("abort_no_done", seen, 0);
    b_dbg = 3'd5;
    #1 chk("abort_r5", b_dbg_data, 32'd0);
    chk("abort_status_after", {28'd0, b_sreg}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
